multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control unit for the multicycle ARM-subset processor. It replaces single-cycle control with a Moore main FSM that sequences one shared ALU, a unified instruction/data memory and the register file across FETCH/DECODE/EXECUTE/MEM/WB cycles. It also holds the NZCV flags register and evaluates condition codes. It supports the existing ISA subset: ADD/SUB/RSB/AND/ORR (register or immediate), LDR, STR, STRB and B.

Parameters:
FLAGS_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
Instr  in  32  from IR; uses Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12]
ALUFlags  in  4  NZCV from ALU, this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0=PC, 1=ALUOut to memory address
MemWrite  out  1  memory write strobe
MemByte  out  1  byte-lane store (STRB)
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  1  0=RD1(A), 1=PC
ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
ImmSrc  out  2  00=DP imm8, 01=mem imm12, 10=branch imm24
RegSrc  out  2  [0]=Rn←R15 (B), [1]=Rm←Rd (STR/STRB)
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
Reverse  out  1  swap ALU operands (RSB)
State  out  4  current state, for debug and bench

Behaviour:
- Reset is asynchronous. It forces state to FETCH and Flags to FLAGS_RESET. While reset is high, PCWrite, MemWrite, RegWrite and IRWrite are 0; the other outputs take their FETCH values.
- Outputs are combinational from state and Instr. Only the state register and Flags are sequential.
- State transitions:
  - FETCH→DECODE always.
  - DECODE→MEMADR if Op=01; →EXECUTER if Op=00 and Funct[5]=0; →EXECUTEI if Op=00 and Funct[5]=1; →BRANCH if Op=10; Op=11 →FETCH (treated as NOP).
  - MEMADR→MEMRD if Funct[0]=1, else →MEMWR.
  - MEMRD→MEMWB.
  - EXECUTER/EXECUTEI→ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH→FETCH.
- Per-state controls (unlisted outputs are 0):
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Drive RegSrc/ImmSrc from Op so the register file reads R15+8.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=00.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1, MemByte=Funct[2].
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ImmSrc=00, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ResultSrc=10, Branch=1.
- ALU decode applies when ALUOp=1, using Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0011 RSB (Reverse=1), 0000 AND, 1100 ORR.
  - Any other value: RegW and FlagW are suppressed (instruction becomes a NOP).
  - FlagW[1]=Funct[0] (N,Z). FlagW[0]=Funct[0] & arithmetic op (C,V).
- Condition logic:
  - CondEx comes from the stored Flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1. Cond=1111 gives 0.
  - Flags[3:2] load ALUFlags[3:2] on the edge ending EXECUTER/EXECUTEI when FlagW[1]&CondEx. Flags[1:0] load under the same rule with FlagW[0].
- Gated outputs:
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCWrite = NextPC | ((Branch | (RegW & Rd==1111)) & CondEx).
  - A failed condition still walks the full state path, with no architectural writes.
- Latency in cycles: B=3, DP=4, STR/STRB=4, LDR=5. There is no stall input, and exactly one instruction is in flight.
- Asserting reset mid-instruction aborts it. No partial writes occur after reset asserts.

Decomposition:
- Package proc_pkg holds:
  - statetype enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
  - Op codes: OP_DP, OP_MEM, OP_B.
  - Cond-code constants.
  - ALUControl and ResultSrc encodings.
- One sub-module, cond_unit: Flags register plus CondEx evaluation and write gating.

Test Plan:
- Reset released → State=FETCH, IRWrite=1, PCWrite=1. Next cycle State=DECODE, PCWrite=0. Flags=0000.
- ADDS R1,R2,R3 (Funct=001001, Cond=1110) with ALUFlags=0110 → states F,D,EXR,ALUWB. RegWrite=1 only in ALUWB. Flags=0110 after EXECUTER.
- LDR (Op=01, Funct=011001) → F,D,MEMADR,MEMRD,MEMWB in 5 cycles. AdrSrc=1 in MEMRD. ResultSrc=01 with RegWrite=1 in MEMWB.
- STRB (Funct=011100) → MEMWR with MemWrite=1 and MemByte=1. STR (Funct=011000) gives MemByte=0.
- BEQ (Cond=0000): with Z=0, the BRANCH state has PCWrite=0; with Z=1, PCWrite=1. Both take 3 cycles.
- RSB imm (Funct=100110) → EXECUTEI with Reverse=1, ALUControl=01. Reset asserted in EXECUTEI → immediately FETCH, RegWrite=0.

Source files
------------

// File: rtl/proc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : proc_pkg                                                      |
// | Purpose  : Shared types and encodings for the multicycle ARM-subset      |
// |            control unit (FSM states, opcodes, condition codes, ALU and   |
// |            result-mux encodings).                                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package proc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } statetype;

  // Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  // Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/cond_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cond_unit                                                     |
// | Purpose  : NZCV flags register, condition-code evaluation and gating of  |
// |            the architectural write enables by the condition result.      |
// | Ports    : clk, reset (async, active-high)                               |
// |            cond_i[3:0]      instruction condition field                  |
// |            alu_flags_i[3:0] NZCV from the ALU this cycle                 |
// |            flag_w_i[1:0]    [1]=load N,Z  [0]=load C,V                    |
// |            reg_w_i, mem_w_i, branch_i, next_pc_i, pc_rd_i  raw controls  |
// |            cond_ex_o, reg_write_o, mem_write_o, pc_write_o               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cond_unit
  import proc_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       branch_i,
  input  logic       next_pc_i,
  input  logic       pc_rd_i,
  output logic       cond_ex_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       pc_write_o
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = flags_q;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = w_z;
      COND_NE: cond_ex_o = ~w_z;
      COND_CS: cond_ex_o = w_c;
      COND_CC: cond_ex_o = ~w_c;
      COND_MI: cond_ex_o = w_n;
      COND_PL: cond_ex_o = ~w_n;
      COND_VS: cond_ex_o = w_v;
      COND_VC: cond_ex_o = ~w_v;
      COND_HI: cond_ex_o = w_c & ~w_z;
      COND_LS: cond_ex_o = ~w_c | w_z;
      COND_GE: cond_ex_o = (w_n == w_v);
      COND_LT: cond_ex_o = (w_n != w_v);
      COND_GT: cond_ex_o = ~w_z & (w_n == w_v);
      COND_LE: cond_ex_o = w_z | (w_n != w_v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;   // 1111 never executes
    endcase
  end

  // N,Z and C,V load independently so logical ops leave C,V untouched.
  always_comb begin
    flags_d = flags_q;
    if (flag_w_i[1] & cond_ex_o) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0] & cond_ex_o) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= FLAGS_RESET;
    else       flags_q <= flags_d;
  end

  assign reg_write_o = reg_w_i & cond_ex_o;
  assign mem_write_o = mem_w_i & cond_ex_o;
  // PC advance in FETCH is unconditional; branches and writes to R15 obey Cond.
  assign pc_write_o  = next_pc_i | ((branch_i | (reg_w_i & pc_rd_i)) & cond_ex_o);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multicycle_ctrl                                               |
// | Purpose  : Moore main FSM and ALU decoder sequencing the shared ALU,     |
// |            unified memory and register file of the multicycle ARM       |
// |            subset (ADD/SUB/RSB/AND/ORR, LDR, STR, STRB, B).              |
// | Ports    : clk, reset (async, active-high), Instr[31:0], ALUFlags[3:0]   |
// |            PCWrite, AdrSrc, MemWrite, MemByte, IRWrite, RegWrite,        |
// |            ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], ImmSrc[1:0],           |
// |            RegSrc[1:0], ALUControl[1:0], Reverse, State[3:0]             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module multicycle_ctrl
  import proc_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        MemByte,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic        Reverse,
  output logic [3:0]  State
);

  statetype   state_q, state_d;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic       w_ir_write, w_next_pc, w_reg_w, w_mem_w, w_branch, w_alu_op;
  logic [1:0] w_flag_w;
  logic [1:0] w_dec_ctrl;
  logic       w_dec_rev, w_dp_valid, w_arith;
  logic       w_cond_ex, w_reg_write, w_mem_write, w_pc_write;
  logic       w_unused;

  assign w_op     = Instr[27:26];
  assign w_funct  = Instr[25:20];
  assign w_unused = ^{Instr[19:16], Instr[11:0], w_cond_ex};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (w_op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = w_funct[5] ? EXECUTEI : EXECUTER;
          OP_B:    state_d = BRANCH;
          default: state_d = FETCH;          // Op=11 behaves as a NOP
        endcase
      end
      MEMADR:             state_d = w_funct[0] ? MEMRD : MEMWR;
      MEMRD:              state_d = MEMWB;
      EXECUTER, EXECUTEI: state_d = ALUWB;
      default:            state_d = FETCH;
    endcase
  end

  // ALU decoder over Funct[4:1]; unsupported encodings are turned into NOPs.
  always_comb begin
    w_dec_ctrl = ALU_ADD;
    w_dec_rev  = 1'b0;
    w_dp_valid = 1'b1;
    w_arith    = 1'b0;
    case (w_funct[4:1])
      4'b0100: begin w_dec_ctrl = ALU_ADD; w_arith = 1'b1; end
      4'b0010: begin w_dec_ctrl = ALU_SUB; w_arith = 1'b1; end
      4'b0011: begin w_dec_ctrl = ALU_SUB; w_arith = 1'b1; w_dec_rev = 1'b1; end
      4'b0000: w_dec_ctrl = ALU_AND;
      4'b1100: w_dec_ctrl = ALU_ORR;
      default: w_dp_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_ir_write = 1'b0;
    w_next_pc  = 1'b0;
    w_reg_w    = 1'b0;
    w_mem_w    = 1'b0;
    w_branch   = 1'b0;
    w_alu_op   = 1'b0;
    AdrSrc     = 1'b0;
    MemByte    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    case (state_q)
      FETCH: begin
        w_ir_write = 1'b1;
        w_next_pc  = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = RES_ALURESULT;
      end
      DECODE: begin
        // PC already holds PC+4, so the ALU produces PC+8 for an R15 read.
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = RES_ALURESULT;
        ImmSrc    = (w_op == OP_B) ? 2'b10 : ((w_op == OP_MEM) ? 2'b01 : 2'b00);
        RegSrc    = {(w_op == OP_MEM) & ~w_funct[0], (w_op == OP_B)};
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        w_reg_w   = 1'b1;
      end
      MEMWR: begin
        AdrSrc  = 1'b1;
        w_mem_w = 1'b1;
        MemByte = w_funct[2];
      end
      EXECUTER: w_alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB  = 2'b01;
        w_alu_op = 1'b1;
      end
      ALUWB:  w_reg_w = w_dp_valid;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = RES_ALURESULT;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl = w_alu_op ? w_dec_ctrl : ALU_ADD;
  assign Reverse    = w_alu_op & w_dec_rev;
  assign w_flag_w   = {2{w_alu_op & w_dp_valid & w_funct[0]}} & {1'b1, w_arith};

  cond_unit #(
    .FLAGS_RESET (FLAGS_RESET)
  ) u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (Instr[31:28]),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (w_flag_w),
    .reg_w_i     (w_reg_w),
    .mem_w_i     (w_mem_w),
    .branch_i    (w_branch),
    .next_pc_i   (w_next_pc),
    .pc_rd_i     (Instr[15:12] == 4'hF),
    .cond_ex_o   (w_cond_ex),
    .reg_write_o (w_reg_write),
    .mem_write_o (w_mem_write),
    .pc_write_o  (w_pc_write)
  );

  // Architectural write strobes are held off for as long as reset is high.
  assign PCWrite  = w_pc_write  & ~reset;
  assign MemWrite = w_mem_write & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign IRWrite  = w_ir_write  & ~reset;
  assign State    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multicycle_ctrl                                            |
// | Purpose  : Self-checking bench for multicycle_ctrl with an instruction-  |
// |            level reference model (state path, gated controls, NZCV).     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, MemByte, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic        ALUSrcA, Reverse;
  logic [3:0]  State;
  logic [17:0] outs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .MemByte(MemByte),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Reverse(Reverse), .State(State)
  );

  assign outs = {PCWrite, AdrSrc, MemWrite, MemByte, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Reverse};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                     input logic [5:0] funct, input logic [3:0] rd);
    return {cond, op, funct, 4'h2, rd, 12'h003};
  endfunction

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 0 = unsupported, 1 ADD, 2 SUB, 3 RSB, 4 AND, 5 ORR
  function automatic int dp_kind(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 1;
      4'b0010: return 2;
      4'b0011: return 3;
      4'b0000: return 4;
      4'b1100: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(input statetype st, input logic [31:0] ins,
                                           input logic [3:0] fl);
    logic pcw, adr, memw, mb, irw, regw, srca, rev, ok, rd15;
    logic [1:0] res, srcb, imm, rsrc, ctl;
    int k;
    {pcw, adr, memw, mb, irw, regw, srca, rev} = '0;
    {res, srcb, imm, rsrc, ctl} = '0;
    ok   = cond_ok(ins[31:28], fl);
    rd15 = (ins[15:12] == 4'hF);
    k    = dp_kind(ins[24:21]);
    case (st)
      FETCH:  begin pcw = 1; irw = 1; srca = 1; srcb = 2; res = 2; end
      DECODE: begin
        srca = 1; srcb = 2; res = 2;
        imm  = (ins[27:26] == 2'b10) ? 2 : (ins[27:26] == 2'b01) ? 1 : 0;
        rsrc = {(ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10};
      end
      MEMADR: begin srcb = 1; imm = 1; end
      MEMRD:  adr = 1;
      MEMWB:  begin res = 1; regw = ok; pcw = ok && rd15; end
      MEMWR:  begin adr = 1; memw = ok; mb = ins[22]; end
      EXECUTER, EXECUTEI: begin
        srcb = (st == EXECUTEI) ? 2'd1 : 2'd0;
        ctl  = (k == 1) ? 2'd0 : (k == 2 || k == 3) ? 2'd1 : (k == 4) ? 2'd2 : (k == 5) ? 2'd3 : 2'd0;
        rev  = (k == 3);
      end
      ALUWB:  begin regw = (k != 0) && ok; pcw = (k != 0) && ok && rd15; end
      BRANCH: begin srcb = 1; imm = 2; res = 2; pcw = ok; end
      default: ;
    endcase
    return {pcw, adr, memw, mb, irw, regw, res, srca, srcb, imm, rsrc, ctl, rev};
  endfunction

  // Execute one instruction from FETCH back to FETCH. Entered and left at posedge+1.
  task automatic run_instr(input logic [31:0] ins, input int force_fl, input string name);
    statetype path[$];
    logic [17:0] mask;
    logic [17:0] e;
    int k;
    Instr = ins;
    k     = dp_kind(ins[24:21]);
    path  = {FETCH, DECODE};
    case (ins[27:26])
      2'b00: path = {path, (ins[25] ? EXECUTEI : EXECUTER), ALUWB};
      2'b01: path = ins[20] ? {path, MEMADR, MEMRD, MEMWB} : {path, MEMADR, MEMWR};
      2'b10: path = {path, BRANCH};
      default: ;
    endcase
    for (int i = 0; i < path.size(); i++) begin
      ALUFlags = (force_fl < 0) ? 4'($urandom_range(0, 15)) : 4'(force_fl);
      @(negedge clk);
      check_eq($sformatf("%s/c%0d/state", name, i), 32'(State), 32'(path[i]));
      e    = exp_ctrl(path[i], ins, m_flags);
      // ALUControl is unspecified for unsupported DP encodings
      mask = (k == 0 && (path[i] == EXECUTER || path[i] == EXECUTEI)) ? 18'h3FFF9 : 18'h3FFFF;
      check_eq($sformatf("%s/c%0d/%s/ctrl", name, i, path[i].name()),
               32'(outs & mask), 32'(e & mask));
      if ((path[i] == EXECUTER || path[i] == EXECUTEI) && k != 0 && ins[20] &&
          cond_ok(ins[31:28], m_flags)) begin
        m_flags[3:2] = ALUFlags[3:2];
        if (k <= 3) m_flags[1:0] = ALUFlags[1:0];
      end
      @(posedge clk); #1;
    end
    check_eq({name, "/flags"}, 32'(dut.u_cond.flags_q), 32'(m_flags));
  endtask

  initial begin
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] dp_ops [5];
    dp_ops = '{4'b0100, 4'b0010, 4'b0011, 4'b0000, 4'b1100};

    reset    = 1'b1;
    Instr    = 32'h0;
    ALUFlags = 4'h0;
    m_flags  = 4'b0000;
    #2;
    check_eq("rst/state",    32'(State),    32'(FETCH));
    check_eq("rst/pcwrite",  32'(PCWrite),  32'd0);
    check_eq("rst/irwrite",  32'(IRWrite),  32'd0);
    check_eq("rst/regwrite", 32'(RegWrite), 32'd0);
    check_eq("rst/memwrite", 32'(MemWrite), 32'd0);
    check_eq("rst/alusrcb",  32'(ALUSrcB),  32'd2);
    check_eq("rst/flags",    32'(dut.u_cond.flags_q), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run_instr(mk(4'hE, 2'b00, 6'b001001, 4'h1), 6, "adds");
    check_eq("adds/flags0110", 32'(dut.u_cond.flags_q), 32'h6);
    run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0), -1, "beq_taken");
    run_instr(mk(4'hE, 2'b00, 6'b000101, 4'h4), 0, "subs_clr");
    run_instr(mk(4'h0, 2'b10, 6'b100000, 4'h0), -1, "beq_not");
    run_instr(mk(4'hE, 2'b01, 6'b011001, 4'h5), -1, "ldr");
    run_instr(mk(4'hE, 2'b01, 6'b011100, 4'h6), -1, "strb");
    run_instr(mk(4'hE, 2'b01, 6'b011000, 4'h7), -1, "str");
    run_instr(mk(4'hE, 2'b00, 6'b011000, 4'hF), -1, "orr_pc");
    run_instr(mk(4'hF, 2'b00, 6'b001000, 4'h1), -1, "nv");
    run_instr(mk(4'hE, 2'b11, 6'b000000, 4'h1), -1, "op11");

    // Reset arriving while an RSB immediate sits in EXECUTEI
    Instr    = mk(4'hE, 2'b00, 6'b100110, 4'h3);
    ALUFlags = 4'hF;
    @(negedge clk); check_eq("rsb/fetch", 32'(State), 32'(FETCH));
    @(posedge clk); #1;
    @(negedge clk); check_eq("rsb/decode", 32'(State), 32'(DECODE));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rsb/exi",     32'(State),      32'(EXECUTEI));
    check_eq("rsb/reverse", 32'(Reverse),    32'd1);
    check_eq("rsb/aluctl",  32'(ALUControl), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rsb/rst_state", 32'(State),    32'(FETCH));
    check_eq("rsb/rst_regw",  32'(RegWrite), 32'd0);
    check_eq("rsb/rst_pcw",   32'(PCWrite),  32'd0);
    check_eq("rsb/rst_irw",   32'(IRWrite),  32'd0);
    m_flags = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rsb/rst_flags", 32'(dut.u_cond.flags_q), 32'd0);

    for (int n = 0; n < 250; n++) begin
      op    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      funct = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 4) != 0)
        funct[4:1] = dp_ops[$urandom_range(0, 4)];
      rd    = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      run_instr(mk(cond, op, funct, rd), -1, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
